// File: rtl/heq_pkg.sv
`default_nettype none
// heq_pkg: shared state encoding, stage indices and width defaults for heq_sequencer.
package heq_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 128;

  localparam int HIST     = 0;
  localparam int CDF      = 1;
  localparam int MAP      = 2;
  localparam int N_STAGES = 3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HIST = 3'd1,
    ST_GAP1 = 3'd2,
    ST_CDF  = 3'd3,
    ST_GAP2 = 3'd4,
    ST_MAP  = 3'd5,
    ST_DONE = 3'd6,
    ST_ERR  = 3'd7
  } heq_state_t;

  // One-hot stage owner implied by the sequencer state; zero when no stage runs.
  function automatic logic [N_STAGES-1:0] owner_of(input heq_state_t s);
    logic [N_STAGES-1:0] o;
    o = '0;
    case (s)
      ST_HIST: o[HIST] = 1'b1;
      ST_CDF:  o[CDF]  = 1'b1;
      ST_MAP:  o[MAP]  = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage
`default_nettype wire

// File: rtl/heq_m2_mux.sv
`default_nettype none
// heq_m2_mux: selects the owning stage's scratchpad m2 port; all zero when no owner.
module heq_m2_mux
  import heq_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [N_STAGES-1:0]        owner,
  input  logic [N_STAGES*ADDR_W-1:0] st_raddr,
  input  logic [N_STAGES*ADDR_W-1:0] st_waddr,
  input  logic [N_STAGES*DATA_W-1:0] st_wdata,
  input  logic [N_STAGES-1:0]        st_we,
  output logic [ADDR_W-1:0]          raddr,
  output logic [ADDR_W-1:0]          waddr,
  output logic [DATA_W-1:0]          wdata,
  output logic                       we
);

  // AND-OR select: owner is one-hot or zero, so OR-ing gated bundles is exact.
  always_comb begin
    raddr = '0;
    waddr = '0;
    wdata = '0;
    we    = 1'b0;
    for (int i = 0; i < N_STAGES; i++) begin
      if (owner[i]) begin
        raddr = raddr | st_raddr[i*ADDR_W +: ADDR_W];
        waddr = waddr | st_waddr[i*ADDR_W +: ADDR_W];
        wdata = wdata | st_wdata[i*DATA_W +: DATA_W];
        we    = we | st_we[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/heq_sequencer.sv
`default_nettype none
// heq_sequencer: runs HIST -> CDF -> MAP per frame and arbitrates the shared m2 port.
// Optional per-stage watchdog enabled by defining HEQ_TIMEOUT_EN.
module heq_sequencer
  import heq_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  go,
  output logic [2:0]            stage_start,
  input  logic [2:0]            stage_done,
  output logic                  base_offset,
  input  logic [3*ADDR_W-1:0]   st_m2_raddr,
  input  logic [3*ADDR_W-1:0]   st_m2_waddr,
  input  logic [3*DATA_W-1:0]   st_m2_wdata,
  input  logic [2:0]            st_m2_we,
  output logic [ADDR_W-1:0]     m2_raddr,
  output logic [ADDR_W-1:0]     m2_waddr,
  output logic [DATA_W-1:0]     m2_wdata,
  output logic                  m2_we,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [7:0]            frame_cnt
);

  heq_state_t state, state_nxt;
  logic [2:0] owner;
  logic       owner_done;
  logic       tmo_hit;

  assign owner      = owner_of(state);
  assign owner_done = |(owner & stage_done);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    stage_start = owner;
    busy        = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    case (state)
      ST_IDLE: if (go) state_nxt = ST_HIST;
      ST_HIST: begin
        busy = 1'b1;
        if (owner_done)   state_nxt = ST_GAP1;
        else if (tmo_hit) state_nxt = ST_ERR;
      end
      ST_GAP1: begin
        busy      = 1'b1;
        state_nxt = ST_CDF;
      end
      ST_CDF: begin
        busy = 1'b1;
        if (owner_done)   state_nxt = ST_GAP2;
        else if (tmo_hit) state_nxt = ST_ERR;
      end
      ST_GAP2: begin
        busy      = 1'b1;
        state_nxt = ST_MAP;
      end
      ST_MAP: begin
        busy = 1'b1;
        if (owner_done)   state_nxt = ST_DONE;
        else if (tmo_hit) state_nxt = ST_ERR;
      end
      ST_DONE: begin
        done = 1'b1;
        if (!go) state_nxt = ST_IDLE;
      end
`ifdef HEQ_TIMEOUT_EN
      ST_ERR: begin
        err = 1'b1;
        if (!go) state_nxt = ST_IDLE;
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef HEQ_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  // Counter restarts on every state change so each stage gets a full budget.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)                  tmo_cnt <= '0;
    else if (state_nxt != state) tmo_cnt <= '0;
    else if (|owner)             tmo_cnt <= tmo_cnt + 16'd1;
  end

  assign tmo_hit = (|owner) && (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  logic unused_tmo;
  assign unused_tmo = |TIMEOUT_CYCLES;
  assign tmo_hit    = 1'b0;
`endif

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt   <= 8'd0;
      base_offset <= 1'b0;
    end else if (state == ST_MAP && owner_done) begin
      frame_cnt   <= frame_cnt + 8'd1;
      base_offset <= ~base_offset;
    end
  end

  heq_m2_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_m2_mux (
    .owner    (owner),
    .st_raddr (st_m2_raddr),
    .st_waddr (st_m2_waddr),
    .st_wdata (st_m2_wdata),
    .st_we    (st_m2_we),
    .raddr    (m2_raddr),
    .waddr    (m2_waddr),
    .wdata    (m2_wdata),
    .we       (m2_we)
  );

endmodule
`default_nettype wire
